// File: rtl/vector_addsub_stream_if.sv
// Stream bundle for vector_addsub_stream: two operand streams in, one result stream out.
// Widths follow PE lanes of IN_WIDTH bits on each input and OUT_WIDTH bits on the output.
// slave  : the add/sub block (consumes in0/in1, produces out0)
// master : the environment (produces in0/in1, consumes out0)
interface vector_addsub_stream_if #(
  parameter int unsigned PE        = 8,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 8
);
  logic [PE*IN_WIDTH-1:0]  in0_V_data_V_TDATA;
  logic                    in0_V_data_V_TVALID;
  logic                    in0_V_data_V_TREADY;
  logic [PE*IN_WIDTH-1:0]  in1_V_data_V_TDATA;
  logic                    in1_V_data_V_TVALID;
  logic                    in1_V_data_V_TREADY;
  logic [PE*OUT_WIDTH-1:0] out0_V_data_V_TDATA;
  logic                    out0_V_data_V_TVALID;
  logic                    out0_V_data_V_TREADY;
  logic                    out0_V_data_V_TLAST;

  modport slave (
    input  in0_V_data_V_TDATA, in0_V_data_V_TVALID,
    output in0_V_data_V_TREADY,
    input  in1_V_data_V_TDATA, in1_V_data_V_TVALID,
    output in1_V_data_V_TREADY,
    output out0_V_data_V_TDATA, out0_V_data_V_TVALID, out0_V_data_V_TLAST,
    input  out0_V_data_V_TREADY
  );

  modport master (
    output in0_V_data_V_TDATA, in0_V_data_V_TVALID,
    input  in0_V_data_V_TREADY,
    output in1_V_data_V_TDATA, in1_V_data_V_TVALID,
    input  in1_V_data_V_TREADY,
    input  out0_V_data_V_TDATA, out0_V_data_V_TVALID, out0_V_data_V_TLAST,
    output out0_V_data_V_TREADY
  );
endinterface

// File: rtl/vector_addsub_stream.sv
// Elementwise a+b / a-b over PE-lane streams with optional signedness and saturation.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   op_sub      : 0 add, 1 subtract (in0 - in1), taken with each accepted beat
//   clr_ovf     : synchronous clear of ovf_sticky (a same-cycle overflow wins)
//   ovf_sticky  : set when any lane of any beat clamped or wrapped
//   bus         : in0/in1 joined operand streams, out0 result stream with TLAST
module vector_addsub_stream #(
  parameter int unsigned PE        = 8,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned SIGNED    = 0,
  parameter int unsigned SATURATE  = 1,
  parameter int unsigned VEC_BEATS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         op_sub,
  input  logic                         clr_ovf,
  output logic                         ovf_sticky,
  vector_addsub_stream_if.slave        bus
);

  localparam int unsigned EW  = IN_WIDTH + 2;
  localparam int unsigned DW  = PE * OUT_WIDTH;
  localparam int unsigned BW  = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1;
  localparam int          LO_I = (SIGNED != 0) ? -(2 ** (OUT_WIDTH - 1)) : 0;
  localparam int          HI_I = (SIGNED != 0) ? (2 ** (OUT_WIDTH - 1)) - 1 : (2 ** OUT_WIDTH) - 1;
  localparam logic signed [EW-1:0] LO = EW'(LO_I);
  localparam logic signed [EW-1:0] HI = EW'(HI_I);

  logic [DW-1:0] res_c;
  logic [PE-1:0] ovf_lane_c;

  // Per-lane exact arithmetic in EW bits, then range check and clamp/wrap.
  for (genvar i = 0; i < PE; i++) begin : g_lane
    logic [IN_WIDTH-1:0]  a_l, b_l;
    logic signed [EW-1:0] a_x, b_x, r_x;
    logic                 hi_c, lo_c;

    assign a_l = bus.in0_V_data_V_TDATA[i*IN_WIDTH +: IN_WIDTH];
    assign b_l = bus.in1_V_data_V_TDATA[i*IN_WIDTH +: IN_WIDTH];

    if (SIGNED != 0) begin : g_sx
      assign a_x = EW'($signed(a_l));
      assign b_x = EW'($signed(b_l));
    end else begin : g_zx
      assign a_x = EW'(a_l);
      assign b_x = EW'(b_l);
    end

    // Unsigned operands still fit a signed EW-bit difference, so one signed compare covers both modes.
    assign r_x  = op_sub ? (a_x - b_x) : (a_x + b_x);
    assign hi_c = (r_x > HI);
    assign lo_c = (r_x < LO);
    assign ovf_lane_c[i] = hi_c | lo_c;

    if (SATURATE != 0) begin : g_sat
      assign res_c[i*OUT_WIDTH +: OUT_WIDTH] = hi_c ? OUT_WIDTH'(HI) :
                                               (lo_c ? OUT_WIDTH'(LO) : OUT_WIDTH'(r_x));
    end else begin : g_wrap
      assign res_c[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(r_x);
    end
  end

  // Two-entry output buffer: entry 0 is the head driving out0.
  logic [DW-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
  logic          last0_q, last0_d, last1_q, last1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          ovf_q, ovf_d;
  logic          room_c, acc_c, pop_c, last_c;

  // Ready depends only on registered occupancy and the peer valid; held low in reset.
  assign room_c = rst_n & (cnt_q != 2'd2);
  assign bus.in0_V_data_V_TREADY = room_c & bus.in1_V_data_V_TVALID;
  assign bus.in1_V_data_V_TREADY = room_c & bus.in0_V_data_V_TVALID;
  assign acc_c  = room_c & bus.in0_V_data_V_TVALID & bus.in1_V_data_V_TVALID;
  assign pop_c  = (cnt_q != 2'd0) & bus.out0_V_data_V_TREADY;
  assign last_c = (beat_q == BW'(VEC_BEATS - 1));

  // Next-state: buffer push/pop, beat counter, sticky overflow.
  always_comb begin
    dat0_d  = dat0_q;
    dat1_d  = dat1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    ovf_d   = ovf_q;

    if (acc_c) begin
      beat_d = last_c ? '0 : beat_q + 1'b1;
    end

    case ({acc_c, pop_c})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          dat0_d  = res_c;
          last0_d = last_c;
        end else begin
          dat1_d  = res_c;
          last1_d = last_c;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        dat0_d  = dat1_q;
        last0_d = last1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new beat lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          dat0_d  = res_c;
          last0_d = last_c;
        end else begin
          dat0_d  = dat1_q;
          last0_d = last1_q;
          dat1_d  = res_c;
          last1_d = last_c;
        end
      end
      default: ;
    endcase

    if (acc_c && (|ovf_lane_c)) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat0_q  <= '0;
      dat1_q  <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      cnt_q   <= 2'd0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out0_V_data_V_TDATA  = dat0_q;
  assign bus.out0_V_data_V_TLAST  = last0_q;
  assign bus.out0_V_data_V_TVALID = (cnt_q != 2'd0);
  assign ovf_sticky               = ovf_q;

endmodule

// File: tb/tb_vector_addsub_stream.sv
// Bench: three instances (unsigned/saturate, unsigned/wrap, signed/saturate) share one
// stimulus; a queue-based lane-arithmetic model predicts every output each cycle.
module tb_vector_addsub_stream;
  localparam int unsigned PE = 4, IW = 8, OW = 8, VB = 3;

  logic        clk, rst_n, sub, clr, va, vb, ordy;
  logic [31:0] a, b;
  logic        ovf_u, ovf_w, ovf_s;
  int          total = 0, bad = 0;

  vector_addsub_stream_if #(.PE(PE), .IN_WIDTH(IW), .OUT_WIDTH(OW)) ifu ();
  vector_addsub_stream_if #(.PE(PE), .IN_WIDTH(IW), .OUT_WIDTH(OW)) ifw ();
  vector_addsub_stream_if #(.PE(PE), .IN_WIDTH(IW), .OUT_WIDTH(OW)) ifs ();

  assign ifu.in0_V_data_V_TDATA = a;  assign ifu.in0_V_data_V_TVALID = va;
  assign ifu.in1_V_data_V_TDATA = b;  assign ifu.in1_V_data_V_TVALID = vb;
  assign ifu.out0_V_data_V_TREADY = ordy;
  assign ifw.in0_V_data_V_TDATA = a;  assign ifw.in0_V_data_V_TVALID = va;
  assign ifw.in1_V_data_V_TDATA = b;  assign ifw.in1_V_data_V_TVALID = vb;
  assign ifw.out0_V_data_V_TREADY = ordy;
  assign ifs.in0_V_data_V_TDATA = a;  assign ifs.in0_V_data_V_TVALID = va;
  assign ifs.in1_V_data_V_TDATA = b;  assign ifs.in1_V_data_V_TVALID = vb;
  assign ifs.out0_V_data_V_TREADY = ordy;

  vector_addsub_stream #(.PE(PE), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SIGNED(0), .SATURATE(1), .VEC_BEATS(VB))
    dut_u (.clk(clk), .rst_n(rst_n), .op_sub(sub), .clr_ovf(clr), .ovf_sticky(ovf_u), .bus(ifu));
  vector_addsub_stream #(.PE(PE), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SIGNED(0), .SATURATE(0), .VEC_BEATS(VB))
    dut_w (.clk(clk), .rst_n(rst_n), .op_sub(sub), .clr_ovf(clr), .ovf_sticky(ovf_w), .bus(ifw));
  vector_addsub_stream #(.PE(PE), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SIGNED(1), .SATURATE(1), .VEC_BEATS(VB))
    dut_s (.clk(clk), .rst_n(rst_n), .op_sub(sub), .clr_ovf(clr), .ovf_sticky(ovf_s), .bus(ifs));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Lane arithmetic from first principles on plain integers.
  function automatic logic [31:0] lanes(input logic [31:0] x, input logic [31:0] y,
                                        input bit s, input bit sgn, input bit sat, output bit ov);
    logic [31:0] r;
    logic [7:0]  xb, yb;
    int          xi, yi, ri, lo, hi;
    r = '0;
    ov = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xb = x[i*8 +: 8];
      yb = y[i*8 +: 8];
      xi = int'(xb);
      yi = int'(yb);
      if (sgn) begin
        if (xb[7]) xi -= 256;
        if (yb[7]) yi -= 256;
      end
      ri = s ? xi - yi : xi + yi;
      lo = sgn ? -128 : 0;
      hi = sgn ? 127 : 255;
      if (ri < lo || ri > hi) begin
        ov = 1'b1;
        if (sat) ri = (ri < lo) ? lo : hi;
      end
      r[i*8 +: 8] = 8'(ri);
    end
    return r;
  endfunction

  typedef struct packed { logic [31:0] d0, d1, d2; logic last; } ent_t;
  ent_t       mq[$];
  int         mbeat;
  logic [2:0] movf;

  // Reference: FIFO of expected results, vector position, sticky flags.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mbeat = 0;
      movf  = '0;
    end else begin
      bit   acc, pop;
      bit   o0, o1, o2;
      ent_t e;
      acc = va && vb && (mq.size() < 2);
      pop = (mq.size() != 0) && ordy;
      o0 = 0; o1 = 0; o2 = 0;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        e.d0   = lanes(a, b, sub, 1'b0, 1'b1, o0);
        e.d1   = lanes(a, b, sub, 1'b0, 1'b0, o1);
        e.d2   = lanes(a, b, sub, 1'b1, 1'b1, o2);
        e.last = (mbeat == VB - 1);
        mbeat  = e.last ? 0 : mbeat + 1;
        mq.push_back(e);
      end
      movf[0] = (acc && o0) ? 1'b1 : (clr ? 1'b0 : movf[0]);
      movf[1] = (acc && o1) ? 1'b1 : (clr ? 1'b0 : movf[1]);
      movf[2] = (acc && o2) ? 1'b1 : (clr ? 1'b0 : movf[2]);
    end
  end

  task automatic cmp_one(input string t, input int k, input logic v, input logic r0, input logic r1,
                         input logic l, input logic o, input logic [31:0] d);
    logic ev;
    ev = rst_n && (mq.size() != 0);
    chk({t, "_valid"}, 32'(v), 32'(ev));
    chk({t, "_rdy0"}, 32'(r0), 32'(rst_n && vb && (mq.size() < 2)));
    chk({t, "_rdy1"}, 32'(r1), 32'(rst_n && va && (mq.size() < 2)));
    chk({t, "_ovf"}, 32'(o), 32'(movf[k]));
    if (ev) begin
      chk({t, "_data"}, d, (k == 0) ? mq[0].d0 : ((k == 1) ? mq[0].d1 : mq[0].d2));
      chk({t, "_last"}, 32'(l), 32'(mq[0].last));
    end else if (!rst_n) begin
      chk({t, "_rst_data"}, d, 32'h0);
      chk({t, "_rst_last"}, 32'(l), 32'h0);
    end
  endtask

  // Compare every cycle, mid-way between edges.
  always @(posedge clk) begin
    #3;
    cmp_one("u", 0, ifu.out0_V_data_V_TVALID, ifu.in0_V_data_V_TREADY, ifu.in1_V_data_V_TREADY,
            ifu.out0_V_data_V_TLAST, ovf_u, ifu.out0_V_data_V_TDATA);
    cmp_one("w", 1, ifw.out0_V_data_V_TVALID, ifw.in0_V_data_V_TREADY, ifw.in1_V_data_V_TREADY,
            ifw.out0_V_data_V_TLAST, ovf_w, ifw.out0_V_data_V_TDATA);
    cmp_one("s", 2, ifs.out0_V_data_V_TVALID, ifs.in0_V_data_V_TREADY, ifs.in1_V_data_V_TREADY,
            ifs.out0_V_data_V_TLAST, ovf_s, ifs.out0_V_data_V_TDATA);
  end

  // Log completed output handshakes of the unsigned/saturate instance.
  logic [32:0] obs[$];
  always @(negedge clk) begin
    #2;
    if (rst_n && ifu.out0_V_data_V_TVALID && ordy)
      obs.push_back({ifu.out0_V_data_V_TLAST, ifu.out0_V_data_V_TDATA});
  end

  task automatic put(input logic [31:0] x, input logic [31:0] y, input bit s);
    int g = 0;
    @(negedge clk);
    a = x; b = y; sub = s; va = 1; vb = 1;
    #1;
    while (!(ifu.in0_V_data_V_TREADY && ifu.in1_V_data_V_TREADY) && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 50) begin
      total++; bad++;
      $display("FAIL put_timeout act=stalled exp=accept t=%0t", $time);
    end
    @(negedge clk);
    va = 0; vb = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drive(input int n, input int pv, input int pr);
    int sent = 0, guard = 0;
    bit pend = 0;
    while (sent < n) begin
      @(negedge clk);
      if (pend) begin sent++; va = 0; vb = 0; pend = 0; end
      if (sent == n) break;
      ordy = ($urandom_range(99) < pr);
      clr  = ($urandom_range(99) < 5);
      if (!(va && vb)) begin
        if ($urandom_range(99) < pv) begin
          a = $urandom; b = $urandom; sub = 1'($urandom_range(1)); va = 1; vb = 1;
        end else begin
          va = 1'($urandom_range(1)); vb = 0;
          if ($urandom_range(1) == 1) begin vb = va; va = 0; end
        end
      end
      #1;
      pend = va && vb && ifu.in0_V_data_V_TREADY && ifu.in1_V_data_V_TREADY;
      guard++;
      if (guard > 20000) begin
        total++; bad++;
        $display("FAIL drive_timeout act=%0d exp=%0d t=%0t", sent, n, $time);
        break;
      end
    end
    @(negedge clk);
    va = 0; vb = 0; clr = 0;
  endtask

  initial begin
    bit o;
    int nacc, n0;
    clk = 0; rst_n = 0; a = '0; b = '0; sub = 0; clr = 0; va = 1; vb = 1; ordy = 0;

    // Hand-computed pins on the model itself.
    chk("model_add", lanes(32'h04030201, 32'h10101010, 1'b0, 1'b0, 1'b1, o), 32'h14131211);
    chk("model_add_ovf", 32'(o), 32'h0);
    chk("model_sat", lanes(32'h000000F0, 32'h00000020, 1'b0, 1'b0, 1'b1, o), 32'h000000FF);
    chk("model_wrap", lanes(32'h000000F0, 32'h00000020, 1'b0, 1'b0, 1'b0, o), 32'h00000010);
    chk("model_ssub", lanes(32'h00000580, 32'h00000701, 1'b1, 1'b1, 1'b1, o), 32'h0000FE80);

    // Reset: readies low even with both valids high.
    repeat (3) @(negedge clk);
    chk("rst_rdy0", 32'(ifu.in0_V_data_V_TREADY), 32'h0);
    chk("rst_rdy1", 32'(ifu.in1_V_data_V_TREADY), 32'h0);
    chk("rst_valid", 32'(ifu.out0_V_data_V_TVALID), 32'h0);
    va = 0; vb = 0;
    @(negedge clk);
    rst_n = 1;

    // Plain add, then saturate/wrap, then signed subtract (third beat of the vector).
    ordy = 1;
    put(32'h04030201, 32'h10101010, 1'b0);
    chk("add_data", ifu.out0_V_data_V_TDATA, 32'h14131211);
    chk("add_valid", 32'(ifu.out0_V_data_V_TVALID), 32'h1);
    chk("add_ovf", 32'(ovf_u), 32'h0);
    put(32'h000000F0, 32'h00000020, 1'b0);
    chk("sat_data", ifu.out0_V_data_V_TDATA, 32'h000000FF);
    chk("wrap_data", ifw.out0_V_data_V_TDATA, 32'h00000010);
    chk("sat_ovf", 32'(ovf_u), 32'h1);
    chk("wrap_ovf", 32'(ovf_w), 32'h1);
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    chk("clr_ovf_u", 32'(ovf_u), 32'h0);
    chk("clr_ovf_w", 32'(ovf_w), 32'h0);
    put(32'h00000580, 32'h00000701, 1'b1);
    chk("ssub_data", ifs.out0_V_data_V_TDATA, 32'h0000FE80);
    chk("usub_data", ifu.out0_V_data_V_TDATA, 32'h0000007F);
    chk("ssub_last", 32'(ifu.out0_V_data_V_TLAST), 32'h1);
    chk("ssub_ovf", 32'(ovf_s), 32'h1);

    // Join: in0 alone is never consumed.
    @(negedge clk);
    a = 32'h01020304; b = 32'h01010101; sub = 0; va = 1; vb = 0;
    repeat (5) begin
      @(negedge clk);
      chk("join_rdy0", 32'(ifu.in0_V_data_V_TREADY), 32'h0);
      chk("join_noout", 32'(ifu.out0_V_data_V_TVALID), 32'h0);
    end
    vb = 1;
    @(negedge clk);
    va = 0; vb = 0;
    chk("join_one", ifu.out0_V_data_V_TDATA, 32'h02030405);
    @(negedge clk);
    chk("join_only_one", 32'(ifu.out0_V_data_V_TVALID), 32'h0);

    // Backpressure: only two beats enter, then all six drain in order.
    do_reset();
    ordy = 0;
    obs.delete();
    nacc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          put({4{8'(i + 1)}}, 32'h0, 1'b0);
          nacc++;
        end
      end
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepted", 32'(nacc), 32'd2);
        chk("bp_rdy0", 32'(ifu.in0_V_data_V_TREADY), 32'h0);
        chk("bp_valid", 32'(ifu.out0_V_data_V_TVALID), 32'h1);
        ordy = 1;
      end
    join
    repeat (5) @(negedge clk);
    chk("bp_count", 32'(obs.size()), 32'd6);
    for (int i = 0; i < 6 && i < obs.size(); i++) begin
      logic [32:0] ob;
      ob = obs[i];
      chk("bp_data", ob[31:0], {4{8'(i + 1)}});
      chk("bp_last", 32'(ob[32]), 32'((i % 3) == 2));
    end

    // Reset mid-vector restarts the beat count.
    do_reset();
    ordy = 1;
    put(32'h11111111, 32'h0, 1'b0);
    put(32'h22222222, 32'h0, 1'b0);
    #3;
    n0 = obs.size();
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(ifu.out0_V_data_V_TVALID), 32'h0);
    chk("mid_rst_data", ifu.out0_V_data_V_TDATA, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) put(32'h30303030 + 32'(i), 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_rst_count", 32'(obs.size()), 32'(n0 + 3));
    for (int i = 0; i < 3 && (n0 + i) < obs.size(); i++) begin
      logic [32:0] ob;
      ob = obs[n0 + i];
      chk("mid_rst_last", 32'(ob[32]), 32'(i == 2));
    end

    // Randomized traffic with varying valid/ready density and occasional clears.
    drive(250, 70, 70);
    drive(150, 90, 30);
    drive(150, 40, 95);
    ordy = 1;
    repeat (5) @(negedge clk);
    chk("drain_valid", 32'(ifu.out0_V_data_V_TVALID), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
